// File: rtl/probe_panel_pkg.sv
// Shared types and constants for the probe panel front end:
// stepper state encoding and the active-low hex glyph table.
package probe_panel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_t;

  // Glyphs packed as {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex2seg(
    input logic [3:0] i_nib
  );
    return SEG_LUT[i_nib];
  endfunction

endpackage

// File: rtl/probe_panel_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, press edge.
// Ports: i_clk, i_rst_n (sync, active-low), i_btn raw -> o_level, o_press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_in;
  logic          w_done;

  assign w_in   = r_sync[1];
  assign w_done = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (w_in == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= w_in;
        r_cnt   <= '0;
        // Pulse lands in the same cycle the level rises.
        r_press <= w_in;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/probe_panel.sv
// Board front end: four debounced buttons, auto-repeat address stepper,
// muxed 7-seg scan. Ports: CLK, Reset_n, buttons, Stop, DataIn, CpuData
// -> Address, VerifyPulse, Segment (active-low), DigitSel (active-low).
module probe_panel
  import probe_panel_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_CYCLES     = 5000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1000000
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic                    NextButton,
  input  logic                    PreButton,
  input  logic                    ClearButton,
  input  logic                    VerifyButton,
  input  logic                    Stop,
  input  logic [4*(DIGITS-1)-1:0] DataIn,
  input  logic [4*(DIGITS-1)-1:0] CpuData,
  output logic [ADDR_W-1:0]       Address,
  output logic                    VerifyPulse,
  output logic [6:0]              Segment,
  output logic [DIGITS-1:0]       DigitSel
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int SW   = $clog2(SCAN_CYCLES + 1);
  localparam int IW   = $clog2(DIGITS);

  logic w_nxt_lvl, w_nxt_prs;
  logic w_pre_lvl, w_pre_prs;
  logic w_clr_prs, w_ver_prs;
  logic w_unused_clr_lvl, w_unused_ver_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nxt (
    .i_clk(CLK), .i_rst_n(Reset_n), .i_btn(NextButton),
    .o_level(w_nxt_lvl), .o_press(w_nxt_prs)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pre (
    .i_clk(CLK), .i_rst_n(Reset_n), .i_btn(PreButton),
    .o_level(w_pre_lvl), .o_press(w_pre_prs)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .i_clk(CLK), .i_rst_n(Reset_n), .i_btn(ClearButton),
    .o_level(w_unused_clr_lvl), .o_press(w_clr_prs)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ver (
    .i_clk(CLK), .i_rst_n(Reset_n), .i_btn(VerifyButton),
    .o_level(w_unused_ver_lvl), .o_press(w_ver_prs)
  );

  // ---------------- stepper ----------------
  step_state_t       r_state;
  logic              r_dir_up;
  logic [RW-1:0]     r_rcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_verify;
  logic              w_held;
  logic [ADDR_W-1:0] w_step_addr;

  // Only the button that started the run can keep it alive.
  assign w_held      = r_dir_up ? w_nxt_lvl : w_pre_lvl;
  assign w_step_addr = r_dir_up ? r_addr + ADDR_W'(1)
                                : r_addr - ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_dir_up <= 1'b1;
      r_rcnt   <= '0;
      r_addr   <= '0;
      r_verify <= 1'b0;
    end else begin
      r_verify <= w_ver_prs & ~Stop;
      if (w_clr_prs) begin
        r_addr  <= '0;
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_rcnt <= '0;
            if (w_nxt_prs && !w_pre_prs) begin
              r_addr   <= r_addr + ADDR_W'(1);
              r_dir_up <= 1'b1;
              r_state  <= ST_DELAY;
            end else if (w_pre_prs && !w_nxt_prs) begin
              r_addr   <= r_addr - ADDR_W'(1);
              r_dir_up <= 1'b0;
              r_state  <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (!w_held) begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
              r_addr  <= w_step_addr;
              r_rcnt  <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (!w_held) begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end else if (r_rcnt == RW'(REPEAT_RATE - 1)) begin
              r_addr <= w_step_addr;
              r_rcnt <= '0;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign Address     = r_addr;
  assign VerifyPulse = r_verify;

  // ---------------- display scan ----------------
  logic [IW-1:0]       r_digit;
  logic [SW-1:0]       r_scan;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dsel;
  logic [IW-1:0]       w_next_digit;
  logic [4*DIGITS-1:0] w_disp;
  logic [3:0]          w_nib;
  logic                w_scan_done;

  assign w_disp       = {4'(r_addr), Stop ? CpuData : DataIn};
  assign w_next_digit = (r_digit == IW'(DIGITS - 1)) ?
                        '0 : r_digit + IW'(1);
  assign w_nib        = w_disp[{w_next_digit, 2'b00} +: 4];
  assign w_scan_done  = (r_scan == SW'(SCAN_CYCLES - 1));

  // Segment and DigitSel load together at each refresh, so data
  // changes only ever show up on a digit boundary.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_digit <= '0;
      r_scan  <= '0;
      r_dsel  <= ~DIGITS'(1);
      r_seg   <= hex2seg(DataIn[3:0]);
    end else if (w_scan_done) begin
      r_scan  <= '0;
      r_digit <= w_next_digit;
      r_dsel  <= ~(DIGITS'(1) << w_next_digit);
      r_seg   <= hex2seg(w_nib);
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  assign Segment  = r_seg;
  assign DigitSel = r_dsel;

endmodule
